// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the minutes:seconds stopwatch.
// Segment patterns are g..a, active-low.
package stopwatch_pkg;

    localparam logic [3:0] MAX_TENS = 4'd5;
    localparam logic [3:0] MAX_ONES = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } run_state_t;

    // One two-digit BCD field (minutes or seconds), range 00..59.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    // Complete architectural state of the core, kept in one register so it
    // can be observed as a single unit.
    typedef struct packed {
        run_state_t state;
        logic       blink;
        logic [1:0] idx;
        bcd_pair_t  mins;
        bcd_pair_t  secs;
    } status_t;

    function automatic logic field_is_last(input bcd_pair_t p);
        return (p.tens == MAX_TENS) && (p.ones == MAX_ONES);
    endfunction

    // Increment a 00..59 field; 59 wraps to 00. Carry is the caller's job.
    function automatic bcd_pair_t bcd_pair_inc(input bcd_pair_t p);
        bcd_pair_t r;
        r = p;
        if (p.ones == MAX_ONES) begin
            r.ones = 4'd0;
            r.tens = (p.tens == MAX_TENS) ? 4'd0 : p.tens + 4'd1;
        end else begin
            r.ones = p.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder (g..a).
// Codes above 9 show a blank digit.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// Minutes:seconds stopwatch with run/pause, field adjust and blinking,
// driving a multiplexed active-low 4-digit seven-segment display.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIGITS = 4
) (
    input  logic                   clk_100mhz,
    input  logic                   rst,
    input  logic                   tick_1hz,
    input  logic                   tick_2hz,
    input  logic                   tick_4hz,
    input  logic                   tick_500hz,
    input  logic                   pause_btn,
    input  logic                   adj,
    input  logic                   sel,
    output logic [6:0]             seg,
    output logic [SCAN_DIGITS-1:0] an,
    output logic                   dp
);

    status_t    status;
    logic       pause_prev;
    logic       pause_rise;
    logic [3:0] digit;
    logic [6:0] digit_seg;
    logic       field_blank;

    assign pause_rise = pause_btn & ~pause_prev;

    // Run/pause FSM, time counters, blink phase and scan index.
    // A pause edge and a count tick in the same cycle: the tick sees the
    // pre-toggle state because both read the current register value.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            status.state <= RUN;
            status.blink <= 1'b1;
            status.idx   <= 2'd0;
            status.mins  <= '0;
            status.secs  <= '0;
            pause_prev   <= 1'b1;
        end else begin
            pause_prev <= pause_btn;

            if (pause_rise) begin
                case (status.state)
                    RUN:     status.state <= PAUSED;
                    PAUSED:  status.state <= RUN;
                    default: status.state <= RUN;
                endcase
            end

            if (tick_4hz) begin
                status.blink <= ~status.blink;
            end

            if (tick_500hz) begin
                status.idx <= status.idx + 2'd1;
            end

            if (adj) begin
                // Adjust mode: only the selected field moves, no carry.
                if (tick_2hz) begin
                    if (sel) begin
                        status.secs <= bcd_pair_inc(status.secs);
                    end else begin
                        status.mins <= bcd_pair_inc(status.mins);
                    end
                end
            end else if ((status.state == RUN) && tick_1hz) begin
                status.secs <= bcd_pair_inc(status.secs);
                if (field_is_last(status.secs)) begin
                    status.mins <= bcd_pair_inc(status.mins);
                end
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        case (status.idx)
            2'd0: digit = status.secs.ones;
            2'd1: digit = status.secs.tens;
            2'd2: digit = status.mins.ones;
            2'd3: digit = status.mins.tens;
            default: digit = 4'd0;
        endcase
    end

    // idx[1] set means a minutes digit is being scanned.
    assign field_blank = adj & ~status.blink & (sel ? ~status.idx[1] : status.idx[1]);

    seg7_decode u_decode (
        .bcd (digit),
        .seg (digit_seg)
    );

    // All display outputs come straight from flops.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            seg <= SEG_0;
            an  <= {{(SCAN_DIGITS-1){1'b1}}, 1'b0};
            dp  <= 1'b1;
        end else begin
            seg <= field_blank ? SEG_BLANK : digit_seg;
            an  <= ~(SCAN_DIGITS'(1) << status.idx);
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: reset, rollover, pause, adjust,
// blink/scan timing, decode patterns and reset mid-operation.
module tb_stopwatch_core;

    logic       clk_100mhz;
    logic       rst;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       tick_4hz;
    logic       tick_500hz;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10];

    stopwatch_core #(.SCAN_DIGITS(4)) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .tick_4hz   (tick_4hz),
        .tick_500hz (tick_500hz),
        .pause_btn  (pause_btn),
        .adj        (adj),
        .sel        (sel),
        .seg        (seg),
        .an         (an),
        .dp         (dp)
    );

    initial begin
        clk_100mhz = 1'b0;
        forever #5 clk_100mhz = ~clk_100mhz;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic pulse_1hz();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
    endtask

    task automatic pulse_4hz();
        tick_4hz = 1'b1;
        step(1);
        tick_4hz = 1'b0;
    endtask

    task automatic pulse_500hz();
        tick_500hz = 1'b1;
        step(1);
        tick_500hz = 1'b0;
    endtask

    task automatic adj_ticks(input int n);
        repeat (n) begin
            tick_2hz = 1'b1;
            step(1);
        end
        tick_2hz = 1'b0;
    endtask

    function automatic logic [15:0] time_now();
        return {dut.status.mins, dut.status.secs};
    endfunction

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0; tick_4hz = 1'b0;
        tick_500hz = 1'b0; pause_btn = 1'b0; adj = 1'b0; sel = 1'b0;

        // Reset values
        step(2);
        check("rst_an", 32'(an), 32'hE);
        check("rst_seg", 32'(seg), 32'h40);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_time", 32'(time_now()), 32'h0000);
        check("rst_state", 32'(dut.status.state), 32'h0);
        check("rst_blink", 32'(dut.status.blink), 32'h1);
        rst = 1'b0;
        step(1);

        // Rollover 59:58 -> 59:59 -> 00:00
        adj = 1'b1; sel = 1'b0;
        adj_ticks(59);
        sel = 1'b1;
        adj_ticks(58);
        check("preload_5958", 32'(time_now()), 32'h5958);
        adj = 1'b0;
        pulse_1hz();
        check("roll_5959", 32'(time_now()), 32'h5959);
        pulse_1hz();
        check("roll_0000", 32'(time_now()), 32'h0000);

        // 00:59 + 1 -> 01:00
        adj = 1'b1; sel = 1'b1;
        adj_ticks(59);
        adj = 1'b0;
        check("preload_0059", 32'(time_now()), 32'h0059);
        pulse_1hz();
        check("carry_0100", 32'(time_now()), 32'h0100);

        // Pause
        pause_btn = 1'b1;
        step(1);
        check("pause_state", 32'(dut.status.state), 32'h1);
        pulse_1hz(); pulse_1hz(); pulse_1hz();
        check("paused_hold", 32'(time_now()), 32'h0100);
        pause_btn = 1'b0; step(1);
        pause_btn = 1'b1; step(1);
        check("resume_state", 32'(dut.status.state), 32'h0);
        pulse_1hz();
        check("resume_count", 32'(time_now()), 32'h0101);
        pause_btn = 1'b0; step(1);
        pause_btn = 1'b1; tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        check("same_cycle_count", 32'(time_now()), 32'h0102);
        check("same_cycle_state", 32'(dut.status.state), 32'h1);
        pulse_1hz();
        check("first_suppressed", 32'(time_now()), 32'h0102);
        pause_btn = 1'b0; step(1);
        pause_btn = 1'b1; step(1);
        pause_btn = 1'b0; step(1);
        check("back_to_run", 32'(dut.status.state), 32'h0);

        // Adjust
        adj = 1'b1; sel = 1'b0;
        adj_ticks(59);
        sel = 1'b1;
        adj_ticks(56);
        check("adj_0058", 32'(time_now()), 32'h0058);
        adj_ticks(3);
        check("adj_sec_wrap", 32'(time_now()), 32'h0001);
        pulse_1hz(); pulse_1hz();
        check("adj_drop_1hz", 32'(time_now()), 32'h0001);
        sel = 1'b0;
        adj_ticks(59);
        check("adj_min_59", 32'(time_now()), 32'h5901);
        adj_ticks(1);
        check("adj_min_wrap", 32'(time_now()), 32'h0001);

        // Blink and scan (adj=1, sel=0 blanks the minutes digits)
        pulse_4hz();
        check("blink_low", 32'(dut.status.blink), 32'h0);
        step(1);
        check("blink_sec_shows", 32'(seg), 32'h79);
        pulse_500hz();
        check("an_lag", 32'(an), 32'hE);
        step(1);
        check("scan_an1", 32'(an), 32'hD);
        check("scan_seg1", 32'(seg), 32'h40);
        pulse_500hz(); step(1);
        check("scan_an2", 32'(an), 32'hB);
        check("scan_seg2_blank", 32'(seg), 32'h7F);
        pulse_500hz(); step(1);
        check("scan_an3", 32'(an), 32'h7);
        check("scan_seg3_blank", 32'(seg), 32'h7F);
        pulse_500hz(); step(1);
        check("scan_an0", 32'(an), 32'hE);
        check("scan_seg0", 32'(seg), 32'h79);

        // Decode sweep on the seconds-ones digit while counting
        adj = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pulse_1hz();
            step(1);
            check($sformatf("decode_%0d", (2 + k) % 10), 32'(seg), 32'(seg_tab[(2 + k) % 10]));
        end

        // Reset mid-operation at 12:34, PAUSED, adj=1
        rst = 1'b1; step(1);
        rst = 1'b0; step(1);
        adj = 1'b1; sel = 1'b0;
        adj_ticks(12);
        sel = 1'b1;
        adj_ticks(34);
        pause_btn = 1'b1; step(1);
        pulse_4hz();
        pulse_500hz();
        check("mid_time", 32'(time_now()), 32'h1234);
        check("mid_state", 32'(dut.status.state), 32'h1);
        check("mid_blink", 32'(dut.status.blink), 32'h0);
        check("mid_idx", 32'(dut.status.idx), 32'h1);
        rst = 1'b1; step(1);
        check("mrst_time", 32'(time_now()), 32'h0000);
        check("mrst_state", 32'(dut.status.state), 32'h0);
        check("mrst_blink", 32'(dut.status.blink), 32'h1);
        check("mrst_idx", 32'(dut.status.idx), 32'h0);
        check("mrst_an", 32'(an), 32'hE);
        check("mrst_seg", 32'(seg), 32'h40);
        check("mrst_dp", 32'(dp), 32'h1);
        rst = 1'b0; step(2);
        check("held_btn_no_toggle", 32'(dut.status.state), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Minutes:seconds stopwatch (00:00–59:59) with pause and field adjust, driving a 4-digit multiplexed active-low seven-segment display. Sits directly downstream of the `clock` tick generator. It consumes that block's single-cycle enable pulses (1 Hz count, 2 Hz adjust, 4 Hz blink, 500 Hz scan) and runs entirely in the `clk_100mhz` domain. Button and switch inputs arrive already debounced and synchronized.

## Interface

Parameters:
- `SCAN_DIGITS`, default 4: number of display digits. Fixed at 4; other values are unsupported.

Ports:
- `clk_100mhz` input 1: the only clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick_1hz` input 1: one-cycle pulse; the count step.
- `tick_2hz` input 1: one-cycle pulse; the adjust increment step.
- `tick_4hz` input 1: one-cycle pulse; the blink phase toggle.
- `tick_500hz` input 1: one-cycle pulse; advances the digit scan.
- `pause_btn` input 1: debounced level. Its rising edge toggles run/pause.
- `adj` input 1: level. 1 = adjust mode.
- `sel` input 1: level. Adjust field: 0 = minutes, 1 = seconds.
- `seg` output 7: segments g..a, active-low. `seg[6]` = g.
- `an` output 4: digit enables, active-low. `an[0]` = seconds ones.
- `dp` output 1: decimal point, active-low. Held at 1 (off).

## Operation

**Time registers**
- BCD fields: `s1` (0–9), `s10` (0–5), `m1` (0–9), `m10` (0–5).

**Run/pause state machine**
- Two states: RUN and PAUSED.
- Each rising edge of `pause_btn` (previous sample 0, current sample 1) toggles the state.
- Toggling works in either mode. The state only has an effect when `adj`=0.

**Count (`adj`=0, RUN, `tick_1hz`)**
- Increment the seconds.
- 59 s rolls to 00 and carries +1 into the minutes.
- 59:59 rolls to 00:00.
- In PAUSED, `tick_1hz` is ignored.

**Adjust (`adj`=1)**
- Normal counting stops regardless of run/pause state.
- On `tick_2hz`, increment the selected field by 1.
- The field wraps 59→00 with no carry into the other field.

**Blink**
- The `blink` bit toggles on every `tick_4hz`.
- When `adj`=1 and `blink`=0, both digits of the selected field are blanked (`seg`=7'h7F).
- `blink` does not advance the scan or affect `an`.

**Scan**
- A 2-bit digit index increments on `tick_500hz` and wraps 3→0.
- Digit mapping: index 0 = `s1`, 1 = `s10`, 2 = `m1`, 3 = `m10`.
- `an` = ~(1 << index).

**Decode**
- Standard active-low patterns, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 5 = 7'b0010010, 9 = 7'b0010000.

**Simultaneous events**
- `pause_btn` edge in the same cycle as `tick_1hz`: the tick uses the pre-toggle state. A RUN→PAUSED toggle still counts that tick.
- `adj` and `sel` are sampled in the same cycle as the tick they qualify.
- `tick_1hz` while `adj`=1 is dropped, not deferred.

**Reset**
- Reset mid-operation, in any state, restores everything below on the next edge.
- Registers: time = 00:00, state = RUN, `blink` = 1, index = 0, pause edge-detect register = 1. Setting the edge-detect register to 1 means a button held through reset does not toggle.
- Outputs: `an` = 4'b1110, `seg` = 7'b1000000, `dp` = 1.

## Timing

- Time registers update on the edge that samples a qualifying tick (cycle N). They are valid at N+1.
- `seg`, `an` and `dp` are registered from the index and time registers. They lag those registers by one cycle.
  - New index at N+1 → `an` and `seg` at N+2.
  - Count tick at N → that digit's `seg` reflects the new value at N+2 at the earliest, when that digit is being scanned.
- Pause edge at cycle N → state valid at N+1. The first suppressed tick is at N+1.
- No output glitches. All outputs come straight from flops.

## Structure

- Package `stopwatch_pkg`:
  - Segment pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK`.
  - `MAX_TENS` = 5, `MAX_ONES` = 9.
  - State encoding: RUN = 1'b0, PAUSED = 1'b1.
- Sub-module `seg7_decode`: combinational, 4-bit BCD in → 7-bit active-low segments out. Instantiated once, after the digit mux.
- The top level holds the edge detect, FSM, BCD counters, blink, scan and output registers.

## Test plan

- **Reset values:** assert `rst` 2 cycles → `an`=1110, `seg`=1000000, `dp`=1, time 00:00, state RUN.
- **Rollover:** preload to 59:58, give 2× `tick_1hz` → 59:59, then 00:00. With 00:59 + 1 tick → 01:00.
- **Pause:** `pause_btn` edge, then 3× `tick_1hz` → time unchanged. Second edge plus 1 tick → +1 s. Edge and tick in the same cycle while RUN → the count still increments once.
- **Adjust:**
  - `adj`=1, `sel`=1, time 00:58, 3× `tick_2hz` → 00:01, minutes unchanged.
  - `sel`=0 from 59:xx, 1 tick → 00:xx.
  - `tick_1hz` is ignored throughout.
- **Blink and scan:**
  - `adj`=1, `sel`=0, one `tick_4hz` → `seg`=7F while index is 2 or 3; seconds digits still show.
  - 4× `tick_500hz` → `an` cycles 1101, 1011, 0111, 1110, each 2 cycles after its tick.
- **Reset mid-run:** at 12:34 in PAUSED with `adj`=1, assert `rst` → next cycle 00:00, RUN, `blink`=1, `an`=1110.
